// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state type, derived address-field widths and constants for cache_ctrl
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE,
        RESP
    } cache_state_t;

    localparam int DEF_NUM_LINES  = 8;
    localparam int DEF_LINE_WORDS = 4;

    localparam logic [31:0] BYTE_MASK = 32'h000000FF;

    function automatic int offset_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int num_lines, input int line_words);
        return 32 - index_w(num_lines) - offset_w(line_words) - 2;
    endfunction

    localparam int OFFSET_W = offset_w(DEF_LINE_WORDS);
    localparam int INDEX_W  = index_w(DEF_NUM_LINES);
    localparam int TAG_W    = tag_w(DEF_NUM_LINES, DEF_LINE_WORDS);

endpackage

// File: rtl/cache_line_store.sv
// rtl/cache_line_store.sv - tag/valid/data arrays with async read, word write and line-fill tag update
module cache_line_store
    import cache_pkg::*;
#(
    parameter int NUM_LINES   = DEF_NUM_LINES,
    parameter int LINE_WORDS  = DEF_LINE_WORDS,
    parameter int INDEX_BITS  = index_w(NUM_LINES),
    parameter int OFFSET_BITS = offset_w(LINE_WORDS),
    parameter int TAG_BITS    = tag_w(NUM_LINES, LINE_WORDS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [INDEX_BITS-1:0]  rd_index_i,
    input  logic [OFFSET_BITS-1:0] rd_offset_i,
    output logic                   rd_valid_o,
    output logic [TAG_BITS-1:0]    rd_tag_o,
    output logic [31:0]            rd_data_o,
    input  logic                   wr_en_i,
    input  logic [INDEX_BITS-1:0]  wr_index_i,
    input  logic [OFFSET_BITS-1:0] wr_offset_i,
    input  logic [31:0]            wr_data_i,
    input  logic                   fill_en_i,
    input  logic [TAG_BITS-1:0]    fill_tag_i,
    input  logic                   clr_en_i,
    input  logic [INDEX_BITS-1:0]  clr_index_i
);

    logic [31:0]          data_q [NUM_LINES*LINE_WORDS];
    logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[{rd_index_i, rd_offset_i}];

    // Only the valid bits need reset; data and tags are qualified by them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else begin
            if (clr_en_i) begin
                valid_q[clr_index_i] <= 1'b0;
            end
            if (fill_en_i) begin
                valid_q[wr_index_i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[{wr_index_i, wr_offset_i}] <= wr_data_i;
        end
        if (fill_en_i) begin
            tag_q[wr_index_i] <= fill_tag_i;
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped write-through cache controller; CACHE_STATS_EN adds hit/miss counters
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int          NUM_LINES     = DEF_NUM_LINES,
    parameter int          LINE_WORDS    = DEF_LINE_WORDS,
    parameter logic [31:0] START_ADDRESS = 32'h10010000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_bw,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic [31:0] mem_addr,
    inout  wire  [31:0] mem_data,
    output logic        mem_ce_n,
    output logic        mem_we_n,
    output logic        mem_oe_n,
    output logic        mem_bw
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int OW = offset_w(LINE_WORDS);
    localparam int IW = index_w(NUM_LINES);
    localparam int TW = tag_w(NUM_LINES, LINE_WORDS);

    cache_state_t state_q, state_d;
    logic [TW-1:0] tag_q;
    logic [IW-1:0] index_q;
    logic [OW-1:0] offset_q, cnt_q;
    logic [31:0]   wdata_q, rdata_q, mem_addr_q;
    logic          bw_q, hit_q;

    logic [TW-1:0] req_tag, rd_tag;
    logic [IW-1:0] req_index;
    logic [OW-1:0] req_offset, wr_offset;
    logic [31:0]   rd_data, wr_data;
    logic          rd_valid, req_hit, accept, refill_last, wr_en, fill_en, clr_en;
    logic          unused_addr_bits;

    assign req_tag          = cpu_addr[31 -: TW];
    assign req_index        = cpu_addr[OW+2 +: IW];
    assign req_offset       = cpu_addr[2 +: OW];
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign req_hit     = rd_valid && (rd_tag == req_tag);
    assign accept      = (state_q == IDLE) && cpu_req;
    assign refill_last = (cnt_q == OW'(LINE_WORDS - 1));

    assign mem_data  = (state_q == WRITE) ? wdata_q : 32'bz;
    assign cpu_rdata = rdata_q;

    cache_line_store #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_store (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_index_i  (req_index),
        .rd_offset_i (req_offset),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_data_o   (rd_data),
        .wr_en_i     (wr_en),
        .wr_index_i  (index_q),
        .wr_offset_i (wr_offset),
        .wr_data_i   (wr_data),
        .fill_en_i   (fill_en),
        .fill_tag_i  (tag_q),
        .clr_en_i    (clr_en),
        .clr_index_i (req_index)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cpu_req) state_d = cpu_we ? WRITE : (req_hit ? RESP : REFILL);
            REFILL:  if (refill_last) state_d = RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_ce_n  = 1'b1;
        mem_we_n  = 1'b1;
        mem_oe_n  = 1'b1;
        mem_bw    = 1'b1;
        mem_addr  = mem_addr_q;
        cpu_ready = 1'b0;
        case (state_q)
            REFILL: begin
                mem_ce_n = 1'b0;
                mem_oe_n = 1'b0;
                mem_addr = {tag_q, index_q, cnt_q, 2'b00};
            end
            WRITE: begin
                mem_ce_n = 1'b0;
                mem_we_n = 1'b0;
                mem_bw   = bw_q;
                mem_addr = {tag_q, index_q, offset_q, 2'b00};
            end
            RESP:    cpu_ready = 1'b1;
            default: ;
        endcase
    end

    // Refill writes every beat; a store touches the line only if it hit, masked like the RAM.
    always_comb begin
        wr_en     = 1'b0;
        wr_offset = cnt_q;
        wr_data   = mem_data;
        if (state_q == REFILL) begin
            wr_en = 1'b1;
        end else if ((state_q == WRITE) && hit_q) begin
            wr_en     = 1'b1;
            wr_offset = offset_q;
            wr_data   = bw_q ? wdata_q : (wdata_q & BYTE_MASK);
        end
    end

    assign fill_en = (state_q == REFILL) && refill_last;
    assign clr_en  = accept && !cpu_we && !req_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_q      <= '0;
            index_q    <= '0;
            offset_q   <= '0;
            cnt_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            bw_q       <= 1'b1;
            hit_q      <= 1'b0;
            mem_addr_q <= START_ADDRESS;
        end else begin
            mem_addr_q <= mem_addr;
            if (accept) begin
                tag_q    <= req_tag;
                index_q  <= req_index;
                offset_q <= req_offset;
                wdata_q  <= cpu_wdata;
                bw_q     <= cpu_bw;
                hit_q    <= req_hit;
                cnt_q    <= '0;
                if (!cpu_we && req_hit) begin
                    rdata_q <= rd_data;
                end
            end
            if (state_q == REFILL) begin
                if (cnt_q == offset_q) begin
                    rdata_q <= mem_data;
                end
                if (!refill_last) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (accept && !cpu_we) begin
            if (req_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (!req_hit && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule
